// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of negedge JK flip-flops: drives J/K on posedge,
// checks the bank's Q against the expected next state after every step.
module jk_bank_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             tc
);

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_CLEAR  = 3'b001;
   localparam logic [2:0] OP_LOAD   = 3'b010;
   localparam logic [2:0] OP_UP     = 3'b011;
   localparam logic [2:0] OP_DOWN   = 3'b100;
   localparam logic [2:0] OP_TOGGLE = 3'b101;
   localparam logic [2:0] OP_HOLD   = 3'b110;
   localparam logic [2:0] OP_RSV    = 3'b111;

   typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

   state_t           state_reg;
   logic [2:0]       op_reg;
   logic [WIDTH-1:0] exp_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             wrap_reg;

   logic [WIDTH-1:0] up_en;
   logic [WIDTH-1:0] dn_en;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] exc_j;
   logic [WIDTH-1:0] exc_k;
   logic [WIDTH-1:0] exc_e;
   logic             exc_wrap;
   logic             op_is_count;

   // Bit i of a counter toggles when every lower bit is 1 (up) or 0 (down).
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_prefix
         if (gi == 0) begin : g_lsb
            assign up_en[gi] = 1'b1;
            assign dn_en[gi] = 1'b1;
         end else begin : g_upper
            assign up_en[gi] = &q_in[gi-1:0];
            assign dn_en[gi] = ~|q_in[gi-1:0];
         end
      end
   endgenerate

   // In IDLE the excitation is for the incoming command; in APPLY it is the next count step.
   assign sel_op = (state_reg == IDLE) ? cmd_op : op_reg;

   always_comb begin
      exc_j    = '0;
      exc_k    = '0;
      exc_e    = q_in;
      exc_wrap = 1'b0;
      case (sel_op)
         OP_CLEAR: begin
            exc_k = '1;
            exc_e = '0;
         end
         OP_LOAD: begin
            exc_j = cmd_data;
            exc_k = ~cmd_data;
            exc_e = cmd_data;
         end
         OP_TOGGLE: begin
            exc_j = cmd_data;
            exc_k = cmd_data;
            exc_e = q_in ^ cmd_data;
         end
         OP_UP: begin
            exc_j    = up_en;
            exc_k    = up_en;
            exc_e    = q_in + WIDTH'(1);
            exc_wrap = &q_in;
         end
         OP_DOWN: begin
            exc_j    = dn_en;
            exc_k    = dn_en;
            exc_e    = q_in - WIDTH'(1);
            exc_wrap = ~|q_in;
         end
         default: ;
      endcase
   end

   assign op_is_count = (op_reg == OP_UP) || (op_reg == OP_DOWN);
   assign cmd_ready   = (state_reg == IDLE);
   assign busy        = (state_reg != IDLE);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         op_reg    <= OP_NOP;
         exp_reg   <= '0;
         cnt_reg   <= '0;
         wrap_reg  <= 1'b0;
         j_out     <= '0;
         k_out     <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         tc        <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cmd_valid) begin
                  tc      <= 1'b0;
                  op_reg  <= cmd_op;
                  cnt_reg <= cmd_count;
                  case (cmd_op)
                     OP_RSV: error <= 1'b1;
                     OP_NOP, OP_HOLD: begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                     end
                     default: begin
                        if ((cmd_op == OP_UP || cmd_op == OP_DOWN) && cmd_count == '0) begin
                           state_reg <= DONE;
                           done      <= 1'b1;
                        end else begin
                           state_reg <= APPLY;
                           j_out     <= exc_j;
                           k_out     <= exc_k;
                           exp_reg   <= exc_e;
                           wrap_reg  <= exc_wrap;
                        end
                     end
                  endcase
               end
            end
            APPLY: begin
               if (q_in != exp_reg) begin
                  state_reg <= IDLE;
                  j_out     <= '0;
                  k_out     <= '0;
                  error     <= 1'b1;
               end else begin
                  tc <= tc | wrap_reg;
                  if (op_is_count && cnt_reg > CNT_W'(1)) begin
                     cnt_reg  <= cnt_reg - CNT_W'(1);
                     j_out    <= exc_j;
                     k_out    <= exc_k;
                     exp_reg  <= exc_e;
                     wrap_reg <= exc_wrap;
                  end else begin
                     state_reg <= DONE;
                     j_out     <= '0;
                     k_out     <= '0;
                     done      <= 1'b1;
                  end
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: negedge JK bank plant, vector table plus
// hand-written corner sequences, results checked through a scoreboard queue.
module tb_jk_bank_sequencer;

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_CLEAR  = 3'b001;
   localparam logic [2:0] OP_LOAD   = 3'b010;
   localparam logic [2:0] OP_UP     = 3'b011;
   localparam logic [2:0] OP_DOWN   = 3'b100;
   localparam logic [2:0] OP_TOGGLE = 3'b101;
   localparam logic [2:0] OP_HOLD   = 3'b110;
   localparam logic [2:0] OP_RSV    = 3'b111;

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'b000;
   logic [3:0] cmd_data = 4'h0;
   logic [7:0] cmd_count = 8'h00;
   logic [3:0] q_in;
   logic [3:0] j_out, k_out;
   logic       busy, done, error, tc;

   logic [3:0] bank_q = 4'hA;
   logic       ovr_en = 1'b0;
   logic [3:0] ovr_val = 4'h0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] q;
      logic       tc;
      logic       err;
      int         lat;
   } exp_t;

   typedef struct {
      logic [2:0] op;
      logic [3:0] d;
      logic [7:0] cnt;
      logic [3:0] q0;
      logic [3:0] eq;
      logic       etc;
      logic       eerr;
      int         lat;
   } vec_t;

   exp_t sb[$];
   vec_t vt[14];

   jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
      .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .q_in(q_in),
      .j_out(j_out), .k_out(k_out), .busy(busy), .done(done), .error(error), .tc(tc)
   );

   always #5 CLK = ~CLK;

   assign q_in = ovr_en ? ovr_val : bank_q;

   // JK bank plant, updates on the falling edge.
   always @(negedge CLK) begin
      for (int i = 0; i < 4; i++) begin
         case ({j_out[i], k_out[i]})
            2'b10:   bank_q[i] <= 1'b1;
            2'b01:   bank_q[i] <= 1'b0;
            2'b11:   bank_q[i] <= ~bank_q[i];
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [3:0] d, input logic [7:0] cnt,
                        input logic [3:0] q0, input exp_t e);
      @(negedge CLK);
      #1;
      bank_q    = q0;
      cmd_op    = op;
      cmd_data  = d;
      cmd_count = cnt;
      cmd_valid = 1'b1;
      check("ready_before_issue", {31'b0, cmd_ready}, 32'd1);
      @(posedge CLK);
      #1;
      cmd_valid = 1'b0;
      sb.push_back(e);
   endtask

   // Waits for done/error, counting falling edges since the accepting posedge.
   task automatic wait_result(input int start, input logic [2:0] op);
      int   k;
      logic hit;
      exp_t e;
      k   = start;
      hit = 1'b0;
      while (!hit && k < 300) begin
         @(negedge CLK);
         k++;
         if (done || error) hit = 1'b1;
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL timeout actual=no_result required=done_or_error");
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty actual=0 required=1");
         return;
      end
      e = sb.pop_front();
      $display("txn op=%0d q=%h tc=%0b done=%0b error=%0b latency=%0d", op, q_in, tc, done, error, k);
      check("latency", k, e.lat);
      check("done", {31'b0, done}, {31'b0, ~e.err});
      check("error", {31'b0, error}, {31'b0, e.err});
      check("q_final", {28'b0, q_in}, {28'b0, e.q});
      check("tc", {31'b0, tc}, {31'b0, e.tc});
      check("jk_idle", {24'b0, j_out, k_out}, 32'd0);
      check("ready_at_result", {31'b0, cmd_ready}, {31'b0, e.err});
   endtask

   initial begin
      vt[0]  = '{OP_LOAD,   4'h5, 8'd0,  4'hA, 4'h5, 1'b0, 1'b0, 2};
      vt[1]  = '{OP_UP,     4'h0, 8'd3,  4'hE, 4'h1, 1'b1, 1'b0, 4};
      vt[2]  = '{OP_DOWN,   4'h0, 8'd2,  4'h1, 4'hF, 1'b1, 1'b0, 3};
      vt[3]  = '{OP_NOP,    4'h0, 8'd0,  4'hB, 4'hB, 1'b0, 1'b0, 1};
      vt[4]  = '{OP_CLEAR,  4'h0, 8'd0,  4'h7, 4'h0, 1'b0, 1'b0, 2};
      vt[5]  = '{OP_TOGGLE, 4'h9, 8'd0,  4'h3, 4'hA, 1'b0, 1'b0, 2};
      vt[6]  = '{OP_RSV,    4'h0, 8'd0,  4'h6, 4'h6, 1'b0, 1'b1, 1};
      vt[7]  = '{OP_UP,     4'h0, 8'd0,  4'h4, 4'h4, 1'b0, 1'b0, 1};
      vt[8]  = '{OP_HOLD,   4'h0, 8'd0,  4'h2, 4'h2, 1'b0, 1'b0, 1};
      vt[9]  = '{OP_UP,     4'h0, 8'd5,  4'h3, 4'h8, 1'b0, 1'b0, 6};
      vt[10] = '{OP_DOWN,   4'h0, 8'd3,  4'h2, 4'hF, 1'b1, 1'b0, 4};
      vt[11] = '{OP_UP,     4'h0, 8'd16, 4'h0, 4'h0, 1'b1, 1'b0, 17};
      vt[12] = '{OP_DOWN,   4'h0, 8'd1,  4'h8, 4'h7, 1'b0, 1'b0, 2};
      vt[13] = '{OP_TOGGLE, 4'hF, 8'd0,  4'hF, 4'h0, 1'b0, 1'b0, 2};

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_ready", {31'b0, cmd_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_jk", {24'b0, j_out, k_out}, 32'd0);
      check("rst_flags", {29'b0, done, error, tc}, 32'd0);
      reset = 1'b1;

      // LOAD with a per-cycle look at the excitation
      issue(OP_LOAD, 4'h5, 8'd0, 4'hA, '{4'h5, 1'b0, 1'b0, 2});
      @(negedge CLK);
      check("load_j", {28'b0, j_out}, 32'h5);
      check("load_k", {28'b0, k_out}, 32'hA);
      check("load_busy", {31'b0, busy}, 32'd1);
      wait_result(1, OP_LOAD);
      @(negedge CLK);
      check("load_jk_after", {24'b0, j_out, k_out}, 32'd0);

      // COUNT_UP across the wrap, tc must stay set after done
      issue(OP_UP, 4'h0, 8'd3, 4'hE, '{4'h1, 1'b1, 1'b0, 4});
      @(negedge CLK);
      @(negedge CLK);
      check("tc_before_wrap", {31'b0, tc}, 32'd0);
      wait_result(2, OP_UP);
      @(negedge CLK);
      check("tc_sticky", {31'b0, tc}, 32'd1);
      check("busy_after_done", {31'b0, busy}, 32'd0);

      // Table vectors
      for (int i = 0; i < 14; i++) begin
         exp_t e;
         e = '{vt[i].eq, vt[i].etc, vt[i].eerr, vt[i].lat};
         issue(vt[i].op, vt[i].d, vt[i].cnt, vt[i].q0, e);
         wait_result(0, vt[i].op);
      end

      // Bank disagrees with the expected TOGGLE result
      issue(OP_TOGGLE, 4'h9, 8'd0, 4'h3, '{4'h0, 1'b0, 1'b1, 2});
      ovr_val = 4'h0;
      ovr_en  = 1'b1;
      wait_result(0, OP_TOGGLE);
      ovr_en = 1'b0;

      // Reset in the middle of a long count
      issue(OP_UP, 4'h0, 8'd10, 4'hE, '{4'h0, 1'b0, 1'b0, 0});
      repeat (4) @(negedge CLK);
      check("mid_tc", {31'b0, tc}, 32'd1);
      check("mid_busy", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      check("abort_jk", {24'b0, j_out, k_out}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_tc", {31'b0, tc}, 32'd0);
      check("abort_ready", {31'b0, cmd_ready}, 32'd1);
      sb.delete();
      @(negedge CLK);
      reset = 1'b1;
      issue(OP_LOAD, 4'h3, 8'd0, bank_q, '{4'h3, 1'b0, 1'b0, 2});
      wait_result(0, OP_LOAD);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

endmodule
